// File: rtl/cdbus_csr_core_if.sv
// CDBUS CSR core bus bundle.
// Carries the host CSR bus (address/read/write/data), the interrupt line and
// sources, the config register image and the RX/TX page-RAM pointer signals.
//   slave  : the CSR core side (drives readdata, irq, cfg, pointers, pulses)
//   master : the host / serial engine / RAM side
`timescale 1ns/1ps
interface cdbus_csr_core_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned N_INT  = 7,
  parameter int unsigned N_CFG  = 8,
  parameter int unsigned PTR_W  = 8
);
  logic [ADDR_W-1:0]       csr_address;
  logic                    csr_read;
  logic [DATA_W-1:0]       csr_readdata;
  logic                    csr_write;
  logic [DATA_W-1:0]       csr_writedata;
  logic                    irq;
  logic [N_INT-1:0]        int_level;
  logic [N_INT-1:0]        int_event;
  logic [N_CFG*DATA_W-1:0] cfg;
  logic [7:0]              rx_rd_data;
  logic [PTR_W-1:0]        rx_rd_addr;
  logic                    rx_rd_done;
  logic                    rx_rd_done_all;
  logic [PTR_W-1:0]        tx_wr_addr;
  logic                    tx_wr_en;
  logic                    tx_switch;

  modport slave (
    input  csr_address, csr_read, csr_write, csr_writedata, int_level, int_event, rx_rd_data,
    output csr_readdata, irq, cfg, rx_rd_addr, rx_rd_done, rx_rd_done_all, tx_wr_addr,
           tx_wr_en, tx_switch
  );

  modport master (
    output csr_address, csr_read, csr_write, csr_writedata, int_level, int_event, rx_rd_data,
    input  csr_readdata, irq, cfg, rx_rd_addr, rx_rd_done, rx_rd_done_all, tx_wr_addr,
           tx_wr_en, tx_switch
  );
endinterface

// File: rtl/cdbus_csr_core.sv
// CDBUS CSR and interrupt core.
// Register file (version, interrupt flag/mask, RX/TX page-RAM data and pointers,
// self-clearing control, generic config registers) with registered read data,
// per-bit sticky or level interrupt flags with write-1-to-clear, and a level or
// one-cycle pulse interrupt output.
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : cdbus_csr_core_if.slave (CSR bus, irq, cfg, RX/TX pointer and pulses)
`timescale 1ns/1ps
module cdbus_csr_core #(
  parameter int unsigned             DATA_W    = 8,
  parameter int unsigned             ADDR_W    = 5,
  parameter int unsigned             N_INT     = 7,
  parameter logic [N_INT-1:0]        STICKY    = 7'b1111000,
  parameter int unsigned             N_CFG     = 8,
  parameter logic [N_CFG*DATA_W-1:0] CFG_RST   = '0,
  parameter int unsigned             PTR_W     = 8,
  parameter bit                      IRQ_PULSE = 1'b0,
  parameter logic [DATA_W-1:0]       VERSION   = DATA_W'(4)
) (
  input logic               clk,
  input logic               reset,
  cdbus_csr_core_if.slave   bus
);

  localparam logic [ADDR_W-1:0] AddrVersion = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] AddrIntFlag = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] AddrIntMask = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] AddrRxData  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] AddrTxData  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] AddrRxAddr  = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] AddrTxAddr  = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] AddrCtrl    = ADDR_W'(7);
  localparam int unsigned       CfgBase     = 8;

  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic [N_INT-1:0]        sticky_q, sticky_d;
  logic [N_INT-1:0]        mask_q, mask_d;
  logic [N_CFG*DATA_W-1:0] cfg_q, cfg_d;
  logic [PTR_W-1:0]        rx_ptr_q, rx_ptr_d;
  logic [PTR_W-1:0]        tx_ptr_q, tx_ptr_d;
  logic                    irq_or_q, irq_or_d;
  logic                    rx_done_q, rx_done_all_q, tx_switch_q;

  logic [N_INT-1:0]  flag;
  logic [DATA_W-1:0] rd_val;
  logic              wr_flag, wr_mask, wr_tx, wr_rxa, wr_txa, wr_ctrl, rd_rx;
  logic [DATA_W-1:0] wdata;

  assign wdata   = bus.csr_writedata;
  assign wr_flag = bus.csr_write && (bus.csr_address == AddrIntFlag);
  assign wr_mask = bus.csr_write && (bus.csr_address == AddrIntMask);
  assign wr_tx   = bus.csr_write && (bus.csr_address == AddrTxData);
  assign wr_rxa  = bus.csr_write && (bus.csr_address == AddrRxAddr);
  assign wr_txa  = bus.csr_write && (bus.csr_address == AddrTxAddr);
  assign wr_ctrl = bus.csr_write && (bus.csr_address == AddrCtrl);
  assign rd_rx   = bus.csr_read  && (bus.csr_address == AddrRxData);

  // Sticky bits come from the latch, the rest follow the live level input.
  assign flag = (STICKY & sticky_q) | (~STICKY & bus.int_level);

  always_comb begin
    rd_val = '0;
    case (bus.csr_address)
      AddrVersion: rd_val = VERSION;
      AddrIntFlag: rd_val = DATA_W'(flag);
      AddrIntMask: rd_val = DATA_W'(mask_q);
      AddrRxData:  rd_val = DATA_W'(bus.rx_rd_data);
      AddrRxAddr:  rd_val = DATA_W'(rx_ptr_q);
      AddrTxAddr:  rd_val = DATA_W'(tx_ptr_q);
      default: begin
        for (int i = 0; i < int'(N_CFG); i++) begin
          if (bus.csr_address == ADDR_W'(CfgBase + i)) rd_val = cfg_q[i*DATA_W +: DATA_W];
        end
      end
    endcase
  end

  always_comb begin
    rdata_d = bus.csr_read ? rd_val : rdata_q;
    // Set beats W1C when both land in the same cycle.
    sticky_d = ((sticky_q & ~(wr_flag ? wdata[N_INT-1:0] : '0)) | bus.int_event) & STICKY;
    mask_d   = wr_mask ? wdata[N_INT-1:0] : mask_q;
    irq_or_d = |(flag & mask_q);

    cfg_d = cfg_q;
    for (int i = 0; i < int'(N_CFG); i++) begin
      if (bus.csr_write && (bus.csr_address == ADDR_W'(CfgBase + i))) begin
        cfg_d[i*DATA_W +: DATA_W] = wdata;
      end
    end

    // Later assignments win: increment < control clear < explicit pointer write.
    rx_ptr_d = rx_ptr_q;
    if (rd_rx) rx_ptr_d = rx_ptr_q + PTR_W'(1);
    if (wr_ctrl && (|wdata[2:0])) rx_ptr_d = '0;
    if (wr_rxa) rx_ptr_d = wdata[PTR_W-1:0];

    tx_ptr_d = tx_ptr_q;
    if (wr_tx) tx_ptr_d = tx_ptr_q + PTR_W'(1);
    if (wr_ctrl && (|wdata[4:3])) tx_ptr_d = '0;
    if (wr_txa) tx_ptr_d = wdata[PTR_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q       <= '0;
      sticky_q      <= '0;
      mask_q        <= '0;
      cfg_q         <= CFG_RST;
      rx_ptr_q      <= '0;
      tx_ptr_q      <= '0;
      irq_or_q      <= 1'b0;
      rx_done_q     <= 1'b0;
      rx_done_all_q <= 1'b0;
      tx_switch_q   <= 1'b0;
    end else begin
      rdata_q       <= rdata_d;
      sticky_q      <= sticky_d;
      mask_q        <= mask_d;
      cfg_q         <= cfg_d;
      rx_ptr_q      <= rx_ptr_d;
      tx_ptr_q      <= tx_ptr_d;
      irq_or_q      <= irq_or_d;
      rx_done_q     <= wr_ctrl & wdata[1];
      rx_done_all_q <= wr_ctrl & wdata[2];
      tx_switch_q   <= wr_ctrl & wdata[4];
    end
  end

  if (IRQ_PULSE) begin : g_irq_pulse
    logic irq_pulse_q;
    // Fires together with the first cycle the registered OR reads 1.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) irq_pulse_q <= 1'b0;
      else       irq_pulse_q <= irq_or_d & ~irq_or_q;
    end
    assign bus.irq = irq_pulse_q;
  end else begin : g_irq_level
    assign bus.irq = irq_or_q;
  end

  assign bus.csr_readdata   = rdata_q;
  assign bus.cfg            = cfg_q;
  assign bus.rx_rd_addr     = rx_ptr_q;
  assign bus.rx_rd_done     = rx_done_q;
  assign bus.rx_rd_done_all = rx_done_all_q;
  assign bus.tx_wr_addr     = tx_ptr_q;
  assign bus.tx_wr_en       = wr_tx;
  assign bus.tx_switch      = tx_switch_q;

endmodule

// File: tb/tb_cdbus_csr_core.sv
// Self-checking bench for cdbus_csr_core: one level-irq and one pulse-irq
// instance share identical stimulus; a behavioural register-map model predicts
// every output after each clock.
`timescale 1ns/1ps
module tb_cdbus_csr_core;

  localparam logic [63:0] CfgRst = 64'h8877_6655_4433_2211;
  localparam logic [6:0]  Sticky = 7'b1111000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       rd_r = 1'b0, wr_r = 1'b0;
  logic [4:0] addr_r = '0;
  logic [7:0] wd_r = '0;
  logic [6:0] lvl_r = '0, ev_r = '0;
  logic [7:0] rx_ram [256];

  cdbus_csr_core_if if_lvl ();
  cdbus_csr_core_if if_pls ();

  assign if_lvl.csr_address   = addr_r;
  assign if_lvl.csr_read      = rd_r;
  assign if_lvl.csr_write     = wr_r;
  assign if_lvl.csr_writedata = wd_r;
  assign if_lvl.int_level     = lvl_r;
  assign if_lvl.int_event     = ev_r;
  assign if_lvl.rx_rd_data    = rx_ram[if_lvl.rx_rd_addr];
  assign if_pls.csr_address   = addr_r;
  assign if_pls.csr_read      = rd_r;
  assign if_pls.csr_write     = wr_r;
  assign if_pls.csr_writedata = wd_r;
  assign if_pls.int_level     = lvl_r;
  assign if_pls.int_event     = ev_r;
  assign if_pls.rx_rd_data    = rx_ram[if_pls.rx_rd_addr];

  cdbus_csr_core #(.CFG_RST(CfgRst), .IRQ_PULSE(1'b0)) u_dut_lvl (
    .clk(clk), .reset(reset), .bus(if_lvl)
  );
  cdbus_csr_core #(.CFG_RST(CfgRst), .IRQ_PULSE(1'b1)) u_dut_pls (
    .clk(clk), .reset(reset), .bus(if_pls)
  );

  // Reference model state
  logic [7:0] m_cfg [8];
  logic [6:0] m_mask, m_sticky;
  logic [7:0] m_rx, m_tx, m_rdata;
  logic       m_or, m_pulse, m_done, m_done_all, m_switch;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_cfg[i] = CfgRst[i*8 +: 8];
    m_mask = '0; m_sticky = '0; m_rx = '0; m_tx = '0; m_rdata = '0;
    m_or = 0; m_pulse = 0; m_done = 0; m_done_all = 0; m_switch = 0;
  endtask

  task automatic model_step();
    logic [6:0] flag;
    logic [7:0] v;
    logic       now_or;
    int         a;
    a = int'(addr_r);
    for (int i = 0; i < 7; i++) flag[i] = Sticky[i] ? m_sticky[i] : lvl_r[i];
    now_or = |(flag & m_mask);
    case (a)
      0: v = 8'd4;
      1: v = {1'b0, flag};
      2: v = {1'b0, m_mask};
      3: v = rx_ram[m_rx];
      5: v = m_rx;
      6: v = m_tx;
      default: v = (a >= 8 && a < 16) ? m_cfg[a-8] : 8'h00;
    endcase
    if (rd_r) m_rdata = v;
    for (int i = 0; i < 7; i++) begin
      if (Sticky[i]) begin
        if (ev_r[i]) m_sticky[i] = 1'b1;
        else if (wr_r && a == 1 && wd_r[i]) m_sticky[i] = 1'b0;
      end
    end
    if (wr_r && a == 2) m_mask = wd_r[6:0];
    if (wr_r && a >= 8 && a < 16) m_cfg[a-8] = wd_r;
    if (rd_r && a == 3) m_rx = m_rx + 8'd1;
    if (wr_r && a == 7 && wd_r[2:0] != 0) m_rx = 8'd0;
    if (wr_r && a == 5) m_rx = wd_r;
    if (wr_r && a == 4) m_tx = m_tx + 8'd1;
    if (wr_r && a == 7 && wd_r[4:3] != 0) m_tx = 8'd0;
    if (wr_r && a == 6) m_tx = wd_r;
    m_done     = wr_r && a == 7 && wd_r[1];
    m_done_all = wr_r && a == 7 && wd_r[2];
    m_switch   = wr_r && a == 7 && wd_r[4];
    m_pulse    = now_or && !m_or;
    m_or       = now_or;
  endtask

  task automatic check_all();
    logic [63:0] exp_cfg;
    for (int i = 0; i < 8; i++) exp_cfg[i*8 +: 8] = m_cfg[i];
    check_eq("readdata", if_lvl.csr_readdata, m_rdata);
    check_eq("irq_level", if_lvl.irq, m_or);
    check_eq("irq_pulse", if_pls.irq, m_pulse);
    check_eq("rx_rd_addr", if_lvl.rx_rd_addr, m_rx);
    check_eq("tx_wr_addr", if_lvl.tx_wr_addr, m_tx);
    check_eq("rx_rd_done", if_lvl.rx_rd_done, m_done);
    check_eq("rx_rd_done_all", if_lvl.rx_rd_done_all, m_done_all);
    check_eq("tx_switch", if_lvl.tx_switch, m_switch);
    check_eq("cfg", if_lvl.cfg, exp_cfg);
  endtask

  // Called at posedge+1; drives one bus cycle and checks the result.
  task automatic cycle(input logic rd, input logic wr, input logic [4:0] a,
                       input logic [7:0] wd, input logic [6:0] ev);
    rd_r = rd; wr_r = wr; addr_r = a; wd_r = wd; ev_r = ev;
    #1;
    check_eq("tx_wr_en", if_lvl.tx_wr_en, wr && a == 5'd4);
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 5'd0, 8'h00, 7'h00);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    cycle(1'b0, 1'b1, a, d, 7'h00);
  endtask

  task automatic rd(input logic [4:0] a);
    cycle(1'b1, 1'b0, a, 8'h00, 7'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) rx_ram[i] = 8'($urandom);
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // Version and config reset values
    rd(5'd0);
    check_eq("version", if_lvl.csr_readdata, 8'd4);
    rd(5'd8);
    check_eq("cfg0_rst", if_lvl.csr_readdata, 8'h11);
    rd(5'd9);
    check_eq("cfg1_rst", if_lvl.csr_readdata, 8'h22);
    idle();

    // Sticky bit 4, W1C, and set-beats-clear
    wr(5'd2, 8'h10);
    cycle(1'b0, 1'b0, 5'd0, 8'h00, 7'h10);
    idle();
    check_eq("sticky_irq", if_lvl.irq, 1'b1);
    wr(5'd1, 8'h10);
    idle();
    check_eq("sticky_cleared", if_lvl.irq, 1'b0);
    cycle(1'b0, 1'b1, 5'd1, 8'h10, 7'h10);
    rd(5'd1);
    check_eq("set_beats_w1c", if_lvl.csr_readdata[4], 1'b1);
    wr(5'd1, 8'h7F);
    idle();

    // Level bit 0
    wr(5'd2, 8'h01);
    lvl_r = 7'h01;
    idle(); idle();
    check_eq("level_irq", if_lvl.irq, 1'b1);
    wr(5'd1, 8'h01);
    idle();
    check_eq("level_w1c_noeffect", if_lvl.irq, 1'b1);
    lvl_r = 7'h00;
    idle(); idle();

    // RX pointer wrap
    wr(5'd5, 8'hFE);
    rd(5'd3); rd(5'd3); rd(5'd3);
    check_eq("rx_wrap_data", if_lvl.csr_readdata, rx_ram[0]);
    check_eq("rx_end_addr", if_lvl.rx_rd_addr, 8'h01);

    // TX writes and commit
    wr(5'd4, 8'hA1); wr(5'd4, 8'hA2); wr(5'd4, 8'hA3);
    wr(5'd7, 8'h10);
    check_eq("tx_switch_pulse", if_lvl.tx_switch, 1'b1);
    idle();

    // Pulse irq: two masked sticky sources, one cleared -> single pulse
    wr(5'd2, 8'h30);
    cycle(1'b0, 1'b0, 5'd0, 8'h00, 7'h30);
    idle(); idle();
    wr(5'd1, 8'h10);
    idle(); idle(); idle();
    wr(5'd1, 8'h7F);
    idle(); idle();

    // Reset in the middle of a CTRL=0x06 write
    rd_r = 0; wr_r = 1; addr_r = 5'd7; wd_r = 8'h06; ev_r = '0;
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    wr_r = 0;
    reset = 1'b0;
    idle();
    check_eq("no_done_after_rst", if_lvl.rx_rd_done | if_lvl.rx_rd_done_all, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      logic [4:0] a;
      logic [6:0] ev;
      a  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
      ev = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h00;
      if ($urandom_range(0, 7) == 0) lvl_r = 7'($urandom);
      cycle(1'($urandom), 1'($urandom), a, 8'($urandom), ev);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
